// File: rtl/reg_file_sb_if.sv
// Register-file bus: two read ports, one write port, one reservation port and
// the scoreboard status outputs.
interface reg_file_sb_if #(
    parameter int NUM_REGS   = 4,
    parameter int DATA_WIDTH = 36
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(NUM_REGS + 1);

    logic [AW-1:0]         i_rs1;
    logic [AW-1:0]         i_rs2;
    logic [AW-1:0]         i_rd;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic                  i_wen;
    logic                  i_rsv_en;
    logic [AW-1:0]         i_rsv_addr;
    logic [DATA_WIDTH-1:0] o_rs1_data;
    logic [DATA_WIDTH-1:0] o_rs2_data;
    logic                  o_rs1_ready;
    logic                  o_rs2_ready;
    logic                  o_rsv_ok;
    logic [CW-1:0]         o_busy_count;

    modport master (
        output i_rs1, i_rs2, i_rd, i_wdata, i_wen, i_rsv_en, i_rsv_addr,
        input  o_rs1_data, o_rs2_data, o_rs1_ready, o_rs2_ready, o_rsv_ok, o_busy_count
    );

    modport slave (
        input  i_rs1, i_rs2, i_rd, i_wdata, i_wen, i_rsv_en, i_rsv_addr,
        output o_rs1_data, o_rs2_data, o_rs1_ready, o_rs2_ready, o_rsv_ok, o_busy_count
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with a pending-bit scoreboard: two read ports, one write port
// that clears pending, and a reservation port that sets it.
module reg_file_sb #(
    parameter int NUM_REGS   = 4,
    parameter int DATA_WIDTH = 36,
    parameter int ZERO_REG   = 0,
    parameter int BYPASS     = 1
) (
    input logic          i_clk,
    input logic          i_rst,
    reg_file_sb_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(NUM_REGS + 1);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_next;
    logic [CW-1:0]         busy_count;
    logic [CW-1:0]         busy_next;
    logic                  wr_eff;
    logic                  rsv_ok;
    logic                  rsv_set;
    logic [AW-1:0]         rd_addr [2];
    logic [DATA_WIDTH-1:0] rd_data [2];
    logic                  rd_ready [2];

    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // A reservation may take a pending register if this same edge's write retires it.
    always_comb begin
        wr_eff  = bus.i_wen && in_range(bus.i_rd) && !is_zero_reg(bus.i_rd);
        rsv_ok  = bus.i_rsv_en && in_range(bus.i_rsv_addr) &&
                  (!pending[bus.i_rsv_addr] ||
                   (bus.i_wen && (bus.i_rd == bus.i_rsv_addr)));
        rsv_set = rsv_ok && !is_zero_reg(bus.i_rsv_addr);
    end

    // Reservation is applied after the write so it wins on a same-register collision.
    always_comb begin
        pending_next = pending;
        if (wr_eff) begin
            pending_next[bus.i_rd] = 1'b0;
        end
        if (rsv_set) begin
            pending_next[bus.i_rsv_addr] = 1'b1;
        end
        busy_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_next = busy_next + CW'(pending_next[i]);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            pending    <= '0;
            busy_count <= '0;
        end else begin
            if (wr_eff) begin
                regs[bus.i_rd] <= bus.i_wdata;
            end
            pending    <= pending_next;
            busy_count <= busy_next;
        end
    end

    assign rd_addr[0] = bus.i_rs1;
    assign rd_addr[1] = bus.i_rs2;

    // Out-of-range addresses and a hardwired R0 read as zero and always ready.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p]  = '0;
            rd_ready[p] = 1'b1;
            if (in_range(rd_addr[p]) && !is_zero_reg(rd_addr[p])) begin
                if ((BYPASS != 0) && wr_eff && (bus.i_rd == rd_addr[p])) begin
                    rd_data[p]  = bus.i_wdata;
                    rd_ready[p] = 1'b1;
                end else begin
                    rd_data[p]  = regs[rd_addr[p]];
                    rd_ready[p] = !pending[rd_addr[p]];
                end
            end
        end
    end

    assign bus.o_rs1_data   = rd_data[0];
    assign bus.o_rs2_data   = rd_data[1];
    assign bus.o_rs1_ready  = rd_ready[0];
    assign bus.o_rs2_ready  = rd_ready[1];
    assign bus.o_rsv_ok     = rsv_ok;
    assign bus.o_busy_count = busy_count;
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a default instance (4 regs, bypass) and a 3-register
// zero-R0 no-bypass instance share stimulus and are scored against a register/pending-array model.
module tb_reg_file_sb;
    localparam int DW = 36;

    logic r_clk = 1'b0;
    logic rst;

    always #5 r_clk = ~r_clk;

    reg_file_sb_if #(.NUM_REGS(4), .DATA_WIDTH(DW)) bus_a ();
    reg_file_sb_if #(.NUM_REGS(3), .DATA_WIDTH(DW)) bus_b ();

    reg_file_sb #(.NUM_REGS(4), .DATA_WIDTH(DW), .ZERO_REG(0), .BYPASS(1)) dut_a (
        .i_clk (r_clk),
        .i_rst (rst),
        .bus   (bus_a.slave)
    );

    reg_file_sb #(.NUM_REGS(3), .DATA_WIDTH(DW), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .i_clk (r_clk),
        .i_rst (rst),
        .bus   (bus_b.slave)
    );

    int    cfg_n   [2] = '{4, 3};
    int    cfg_zr  [2] = '{0, 1};
    int    cfg_byp [2] = '{1, 0};
    string cfg_name[2] = '{"A", "B"};

    int total_checks = 0;
    int bad_checks   = 0;

    logic [1:0]    s_rs1, s_rs2, s_rd, s_rsv_addr;
    logic [DW-1:0] s_wdata;
    logic          s_wen, s_rsv_en;

    logic [DW-1:0] m_data [2][4];
    logic          m_pend [2][4];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] rs1, input logic [1:0] rs2, input logic [1:0] rd,
                                 input logic [DW-1:0] wdata, input logic wen, input logic rsv_en,
                                 input logic [1:0] rsv_addr);
        s_rs1 = rs1; s_rs2 = rs2; s_rd = rd; s_wdata = wdata;
        s_wen = wen; s_rsv_en = rsv_en; s_rsv_addr = rsv_addr;
        bus_a.i_rs1 = rs1; bus_a.i_rs2 = rs2; bus_a.i_rd = rd; bus_a.i_wdata = wdata;
        bus_a.i_wen = wen; bus_a.i_rsv_en = rsv_en; bus_a.i_rsv_addr = rsv_addr;
        bus_b.i_rs1 = rs1; bus_b.i_rs2 = rs2; bus_b.i_rd = rd; bus_b.i_wdata = wdata;
        bus_b.i_wen = wen; bus_b.i_rsv_en = rsv_en; bus_b.i_rsv_addr = rsv_addr;
        #1;
    endtask

    function automatic logic model_writes(int k);
        return s_wen && (int'(s_rd) < cfg_n[k]) && !((cfg_zr[k] != 0) && (s_rd == 2'd0));
    endfunction

    // Returns {ready, data} for a read of address a on configuration k.
    function automatic logic [DW:0] model_read(int k, logic [1:0] a);
        if ((int'(a) >= cfg_n[k]) || ((cfg_zr[k] != 0) && (a == 2'd0)))
            return {1'b1, {DW{1'b0}}};
        if ((cfg_byp[k] != 0) && model_writes(k) && (s_rd == a))
            return {1'b1, s_wdata};
        return {!m_pend[k][a], m_data[k][a]};
    endfunction

    function automatic logic model_rsv_ok(int k);
        return s_rsv_en && (int'(s_rsv_addr) < cfg_n[k]) &&
               (!m_pend[k][s_rsv_addr] || (s_wen && (s_rd == s_rsv_addr)));
    endfunction

    function automatic int model_count(int k);
        int c = 0;
        for (int i = 0; i < 4; i++) c += int'(m_pend[k][i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                m_data[k][i] = '0;
                m_pend[k][i] = 1'b0;
            end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic w, ok;
            w  = model_writes(k);
            ok = model_rsv_ok(k);
            if (w) begin
                m_data[k][s_rd] = s_wdata;
                m_pend[k][s_rd] = 1'b0;
            end
            if (ok && !((cfg_zr[k] != 0) && (s_rsv_addr == 2'd0)))
                m_pend[k][s_rsv_addr] = 1'b1;
        end
    endtask

    task automatic check_comb();
        logic [DW-1:0] d1 [2], d2 [2];
        logic          r1 [2], r2 [2], ok [2];
        logic [DW:0]   e1, e2;
        d1[0] = bus_a.o_rs1_data;  d1[1] = bus_b.o_rs1_data;
        d2[0] = bus_a.o_rs2_data;  d2[1] = bus_b.o_rs2_data;
        r1[0] = bus_a.o_rs1_ready; r1[1] = bus_b.o_rs1_ready;
        r2[0] = bus_a.o_rs2_ready; r2[1] = bus_b.o_rs2_ready;
        ok[0] = bus_a.o_rsv_ok;    ok[1] = bus_b.o_rsv_ok;
        for (int k = 0; k < 2; k++) begin
            e1 = model_read(k, s_rs1);
            e2 = model_read(k, s_rs2);
            checkOutput($sformatf("%s rs1_data", cfg_name[k]), 64'(d1[k]), 64'(e1[DW-1:0]));
            checkOutput($sformatf("%s rs2_data", cfg_name[k]), 64'(d2[k]), 64'(e2[DW-1:0]));
            checkOutput($sformatf("%s rs1_ready", cfg_name[k]), 64'(r1[k]), 64'(e1[DW]));
            checkOutput($sformatf("%s rs2_ready", cfg_name[k]), 64'(r2[k]), 64'(e2[DW]));
            checkOutput($sformatf("%s rsv_ok", cfg_name[k]), 64'(ok[k]), 64'(model_rsv_ok(k)));
        end
    endtask

    task automatic check_count();
        checkOutput("A busy_count", 64'(bus_a.o_busy_count), 64'(model_count(0)));
        checkOutput("B busy_count", 64'(bus_b.o_busy_count), 64'(model_count(1)));
    endtask

    // Called just after applyStimulus: check combinational outputs, clock once, check the count.
    task automatic step_cycle();
        check_comb();
        @(posedge r_clk);
        model_edge();
        #1;
        check_count();
        @(negedge r_clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_comb();
        check_count();
        rst = 1'b0;
    endtask

    logic [35:0] init_vals [4];

    initial begin
        init_vals = '{36'h11, 36'h22, 36'h33, 36'h123456789};
        rst = 1'b1;
        model_reset();
        applyStimulus(2'd0, 2'd0, 2'd0, '0, 1'b0, 1'b0, 2'd0);
        check_comb();
        check_count();
        @(negedge r_clk);
        rst = 1'b0;

        for (int a = 0; a < 4; a++) begin
            applyStimulus(2'(a), 2'(a), 2'd0, '0, 1'b0, 1'b0, 2'd0);
            checkOutput("A reset data", 64'(bus_a.o_rs1_data), 64'h0);
            checkOutput("A reset ready", 64'(bus_a.o_rs2_ready), 64'h1);
            step_cycle();
        end

        for (int a = 0; a < 4; a++) begin
            applyStimulus(2'(a), 2'(a), 2'(a), init_vals[a], 1'b1, 1'b0, 2'd0);
            step_cycle();
        end
        applyStimulus(2'd3, 2'd3, 2'd3, 36'h555, 1'b0, 1'b0, 2'd0);
        checkOutput("A R3 hold", 64'(bus_a.o_rs1_data), 64'h123456789);
        step_cycle();

        applyStimulus(2'd2, 2'd2, 2'd0, '0, 1'b0, 1'b1, 2'd2);
        checkOutput("A rsv R2 ok", 64'(bus_a.o_rsv_ok), 64'h1);
        step_cycle();
        applyStimulus(2'd2, 2'd2, 2'd0, '0, 1'b0, 1'b1, 2'd2);
        checkOutput("A R2 not ready", 64'(bus_a.o_rs1_ready), 64'h0);
        checkOutput("A rsv R2 again", 64'(bus_a.o_rsv_ok), 64'h0);
        checkOutput("A count one", 64'(bus_a.o_busy_count), 64'h1);
        step_cycle();
        applyStimulus(2'd2, 2'd2, 2'd2, 36'hAB, 1'b1, 1'b0, 2'd0);
        step_cycle();
        applyStimulus(2'd2, 2'd2, 2'd0, '0, 1'b0, 1'b0, 2'd0);
        checkOutput("A R2 ready", 64'(bus_a.o_rs1_ready), 64'h1);
        checkOutput("A count zero", 64'(bus_a.o_busy_count), 64'h0);
        step_cycle();

        applyStimulus(2'd1, 2'd1, 2'd1, 36'hF0, 1'b1, 1'b0, 2'd0);
        checkOutput("A bypass rs1", 64'(bus_a.o_rs1_data), 64'hF0);
        checkOutput("A bypass rs2", 64'(bus_a.o_rs2_data), 64'hF0);
        checkOutput("B no bypass", 64'(bus_b.o_rs1_data), 64'h22);
        step_cycle();
        applyStimulus(2'd1, 2'd1, 2'd0, '0, 1'b0, 1'b0, 2'd0);
        checkOutput("B late write", 64'(bus_b.o_rs2_data), 64'hF0);
        step_cycle();

        applyStimulus(2'd3, 2'd3, 2'd0, '0, 1'b0, 1'b1, 2'd3);
        step_cycle();
        applyStimulus(2'd3, 2'd3, 2'd3, 36'h7, 1'b1, 1'b1, 2'd3);
        checkOutput("A rsv with write", 64'(bus_a.o_rsv_ok), 64'h1);
        step_cycle();
        applyStimulus(2'd3, 2'd3, 2'd0, '0, 1'b0, 1'b0, 2'd0);
        checkOutput("A R3 data 7", 64'(bus_a.o_rs1_data), 64'h7);
        checkOutput("A R3 still pending", 64'(bus_a.o_rs1_ready), 64'h0);
        step_cycle();
        applyStimulus(2'd0, 2'd0, 2'd0, 36'h99, 1'b1, 1'b0, 2'd0);
        step_cycle();
        applyStimulus(2'd0, 2'd0, 2'd0, '0, 1'b0, 1'b0, 2'd0);
        checkOutput("B R0 zero", 64'(bus_b.o_rs1_data), 64'h0);
        checkOutput("A R0 written", 64'(bus_a.o_rs1_data), 64'h99);
        step_cycle();

        for (int a = 0; a < 4; a++) begin
            applyStimulus(2'd0, 2'd0, 2'd0, '0, 1'b0, 1'b1, 2'(a));
            step_cycle();
        end
        applyStimulus(2'd0, 2'd1, 2'd0, '0, 1'b0, 1'b0, 2'd0);
        checkOutput("A count full", 64'(bus_a.o_busy_count), 64'h4);
        rst = 1'b1;
        #1;
        model_reset();
        checkOutput("A count after rst", 64'(bus_a.o_busy_count), 64'h0);
        for (int a = 0; a < 4; a++) begin
            applyStimulus(2'(a), 2'(3 - a), 2'd0, '0, 1'b0, 1'b0, 2'd0);
            check_comb();
        end
        rst = 1'b0;
        step_cycle();

        for (int n = 0; n < 400; n++) begin
            logic [DW-1:0] wd;
            wd = {$urandom(), $urandom()};
            applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          wd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)));
            if ($urandom_range(0, 49) == 0) pulse_reset();
            step_cycle();
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of architectural registers (>=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 36, register width in bits.
REQ-003 SHALL have parameter ZERO_REG, default 0; 1 = R0 hardwired to zero.
REQ-004 SHALL have parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding.
REQ-005 SHALL define local AW = $clog2(NUM_REGS) and CW = $clog2(NUM_REGS+1).
REQ-006 i_clk  input  1  sole clock, rising edge active.
REQ-007 i_rst  input  1  asynchronous, active-high reset.
REQ-008 i_rs1  input  AW  read port 1 address.
REQ-009 i_rs2  input  AW  read port 2 address.
REQ-010 i_rd  input  AW  write address.
REQ-011 i_wdata  input  DATA_WIDTH  write data.
REQ-012 i_wen  input  1  write enable; a write also clears the pending bit of i_rd.
REQ-013 i_rsv_en  input  1  reservation request; marks i_rsv_addr pending.
REQ-014 i_rsv_addr  input  AW  register to reserve.
REQ-015 o_rs1_data / o_rs2_data  output  DATA_WIDTH  combinational read data.
REQ-016 o_rs1_ready / o_rs2_ready  output  1  read operand not pending (or forwarded).
REQ-017 o_rsv_ok  output  1  combinational: current reservation request is accepted.
REQ-018 o_busy_count  output  CW  registered count of pending registers.

Function
REQ-019 Storage SHALL be NUM_REGS x DATA_WIDTH registers plus NUM_REGS pending bits, updated on rising i_clk.
REQ-020 Write: i_wen=1 at an edge SHALL load i_wdata into R[i_rd] and clear pending[i_rd]; i_wen=0 SHALL leave all data unchanged.
REQ-021 A write to a non-pending register SHALL still update data; pending stays 0.
REQ-022 o_rsv_ok SHALL be 1 when i_rsv_en=1 and pending[i_rsv_addr]=0, or when i_rsv_en=1 and i_wen=1 and i_rd==i_rsv_addr; else 0.
REQ-023 Accepted reservation SHALL set pending[i_rsv_addr] at the edge; rejected one SHALL change nothing.
REQ-024 Same-edge write and accepted reservation to the same register: data SHALL be written and pending SHALL end at 1 (reservation wins).
REQ-025 Read ports SHALL be fully independent; both may address the same register.
REQ-026 o_rsN_data SHALL be R[i_rsN]; o_rsN_ready SHALL be !pending[i_rsN].
REQ-027 BYPASS=1: if i_wen=1 and i_rd==i_rsN, o_rsN_data SHALL be i_wdata and o_rsN_ready SHALL be 1.
REQ-028 BYPASS=0: read data SHALL reflect only stored values (one-cycle write-to-read latency).
REQ-029 ZERO_REG=1: writes to R0 SHALL be ignored; reads of R0 SHALL return 0 with ready=1 (no bypass); reservation of R0 SHALL be accepted without setting pending.
REQ-030 Addresses >= NUM_REGS (non-power-of-two depth) SHALL read 0 with ready=1; writes/reservations to them SHALL be ignored, o_rsv_ok=0.
REQ-031 o_busy_count SHALL equal the number of set pending bits after each edge, range 0..NUM_REGS, never wrapping.

Reset
REQ-032 i_rst=1 SHALL immediately, without a clock, clear all data registers, all pending bits and o_busy_count to 0.
REQ-033 While i_rst=1, writes and reservations SHALL be ignored; read outputs SHALL show data 0, ready 1 (bypass path excepted when BYPASS=1 and i_wen=1).
REQ-034 Reset asserted mid-operation (pending bits set) SHALL discard all pending state; first edge after deassertion operates normally.

Verification (defaults NUM_REGS=4, DATA_WIDTH=36)
REQ-035 Reset, then read R0..R3 on both ports -> data 0, ready 1, o_busy_count 0.
REQ-036 Write 0x11,0x22,0x33,0x123456789 to R0..R3, then i_wen=0 with i_rd=3, i_wdata=0x555 -> R3 reads 0x123456789.
REQ-037 Reserve R2 -> o_rsv_ok 1, next cycle o_rs1_ready 0 for rs1=2, busy_count 1; reserve R2 again -> o_rsv_ok 0, count stays 1; write R2=0xAB -> ready 1, count 0.
REQ-038 BYPASS=1, i_wen=1 i_rd=1 i_wdata=0xF0, rs1=rs2=1 -> both ports show 0xF0 in same cycle; BYPASS=0 -> old value until next cycle.
REQ-039 Same edge: write R3=0x7 and reserve R3 (pending) -> R3=0x7 stored, pending remains 1; ZERO_REG=1 write R0=0x99 -> R0 reads 0.
REQ-040 Reserve R0..R3 (count 4), assert i_rst between clock edges -> immediate count 0, all ready 1, data 0.
